// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  localparam int CD_WIDTH = 4;

endpackage

// File: rtl/countdown_if.sv
// Control/status bundle of the countdown timer; state is exported for debug.
interface countdown_if
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] d;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             zero;
  cd_state_t        state;

  // Level controls, no handshake: load > start > pause, all sampled on every rising clk edge.
  modport master (
    output load, d, start, pause,
    input  q, busy, done, zero, state
  );

  modport slave (
    input  load, d, start, pause,
    output q, busy, done, zero, state
  );

endinterface

// File: rtl/countdown_tick_gen.sv
// Prescaler producing a one-cycle count enable every DIV enabled cycles.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/countdown_top.sv
// Loadable down counter with run/pause control and a one-cycle done pulse.
module countdown_top
  import countdown_pkg::*;
#(
  parameter int DIV   = 50_000_000,
  parameter int WIDTH = CD_WIDTH
) (
  input  logic        clk,
  input  logic        rs,
  countdown_if.slave  bus
);

  cd_state_t        state;
  cd_state_t        base_state_n;
  cd_state_t        state_n;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             busy;
  logic             done;
  logic             count_en;
  logic             clr;
  logic             tick;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rs   (rs),
    .en   (count_en),
    .clr  (clr),
    .tick (tick)
  );

  // Control decisions that do not depend on tick, kept apart so tick never loops back.
  always_comb begin
    base_state_n = state;
    count_en     = 1'b0;
    clr          = 1'b0;
    if (bus.load) begin
      base_state_n = IDLE;
      clr          = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (q != '0)) begin
            base_state_n = RUN;
            clr          = 1'b1;
          end
        end
        RUN: begin
          if (!bus.start && bus.pause) begin
            base_state_n = PAUSE;
          end else begin
            count_en = 1'b1;
          end
        end
        PAUSE: begin
          // The resume cycle counts, so a pause stretches the interval by its length only.
          if (bus.start) begin
            base_state_n = RUN;
            count_en     = 1'b1;
          end
        end
        DONE:    base_state_n = IDLE;
        default: base_state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    state_n = base_state_n;
    q_n     = q;
    if (bus.load) begin
      q_n = bus.d;
    end else if (tick) begin
      if (q == WIDTH'(1)) begin
        q_n     = '0;
        state_n = DONE;
      end else begin
        q_n = q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      busy  <= (state_n == RUN) || (state_n == PAUSE);
      done  <= (state_n == DONE);
    end
  end

  assign bus.q     = q;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.zero  = (q == '0);
  assign bus.state = state;

endmodule

// File: tb/tb_countdown_top.sv
// Bench for countdown_top: directed scenarios plus random stimulus against a cycle-count model.
module tb_countdown_top;
  import countdown_pkg::*;

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_if #(.WIDTH(4)) bus4 ();
  countdown_if #(.WIDTH(4)) bus1 ();

  assign bus4.load = load;  assign bus1.load = load;
  assign bus4.d = d;        assign bus1.d = d;
  assign bus4.start = start; assign bus1.start = start;
  assign bus4.pause = pause; assign bus1.pause = pause;

  countdown_top #(.DIV(4), .WIDTH(4)) dut4 (.clk(clk), .rs(rs), .bus(bus4));
  countdown_top #(.DIV(1), .WIDTH(4)) dut1 (.clk(clk), .rs(rs), .bus(bus1));

  // Model: remaining cycles until the next decrement, per instance.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_q[2];
  int m_mode[2];
  int m_left[2];
  bit m_done[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_mode[i] = M_IDLE; m_left[i] = 0; m_done[i] = 0;
    end
  endfunction

  function automatic void model_step(int i, int div);
    bit counting;
    m_done[i] = 0;
    counting  = 0;
    if (load) begin
      m_q[i] = d;
      m_mode[i] = M_IDLE;
    end else begin
      case (m_mode[i])
        M_IDLE: if (start && m_q[i] != 0) begin m_mode[i] = M_RUN; m_left[i] = div; end
        M_RUN: begin
          if (!start && pause) m_mode[i] = M_PAUSE;
          else counting = 1;
        end
        M_PAUSE: if (start) begin m_mode[i] = M_RUN; counting = 1; end
        default: m_mode[i] = M_IDLE;
      endcase
      if (counting) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_left[i] = div;
          m_q[i] = m_q[i] - 1;
          if (m_q[i] == 0) begin m_mode[i] = M_DONE; m_done[i] = 1; end
        end
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rs) model_reset();
    else begin
      model_step(0, 4);
      model_step(1, 1);
    end
    @(negedge clk);
  endtask

  task automatic load_value(input logic [3:0] v);
    load = 1'b1; d = v;
    cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rs = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus4.q !== 4'd0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_div4: q=%0d busy=%0b done=%0b zero=%0b expected q=0 busy=0 done=0 zero=1",
               bus4.q, bus4.busy, bus4.done, bus4.zero);
    end
    checks++;
    if (bus1.q !== 4'd0 || bus1.busy !== 1'b0 || bus1.zero !== 1'b1 || bus1.state !== IDLE) begin
      errors++;
      $display("FAIL reset_div1: q=%0d busy=%0b zero=%0b expected q=0 busy=0 zero=1", bus1.q, bus1.busy, bus1.zero);
    end
    cycle(); cycle();
    rs = 1'b1;
    cycle();
  endtask

  task automatic test_countdown();
    logic [3:0] eq;
    load_value(4'd3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int j = 0; j <= 14; j++) begin
      if (j > 0) cycle();
      eq = (j < 4) ? 4'd3 : (j < 8) ? 4'd2 : (j < 12) ? 4'd1 : 4'd0;
      checks++;
      if (bus4.q !== eq || bus4.done !== (j == 12) || bus4.busy !== (j < 12)) begin
        errors++;
        $display("FAIL countdown j=%0d: q=%0d done=%0b busy=%0b expected q=%0d done=%0b busy=%0b",
                 j, bus4.q, bus4.done, bus4.busy, eq, (j == 12), (j < 12));
      end
    end
  endtask

  task automatic test_pause();
    logic [3:0] eq;
    load_value(4'd2);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int j = 0; j <= 15; j++) begin
      if (j > 0) cycle();
      pause = (j >= 1 && j <= 5);
      start = (j == 6);
      eq = (j < 9) ? 4'd2 : (j < 13) ? 4'd1 : 4'd0;
      checks++;
      if (bus4.q !== eq || bus4.done !== (j == 13) || bus4.busy !== (j < 13)) begin
        errors++;
        $display("FAIL pause j=%0d: q=%0d done=%0b busy=%0b expected q=%0d done=%0b busy=%0b",
                 j, bus4.q, bus4.done, bus4.busy, eq, (j == 13), (j < 13));
      end
      if (j >= 2 && j <= 6) begin
        checks++;
        if (bus4.state !== PAUSE) begin
          errors++;
          $display("FAIL pause_state j=%0d: state=%0d expected %0d", j, bus4.state, PAUSE);
        end
      end
    end
    pause = 1'b0; start = 1'b0;
  endtask

  task automatic test_zero_start();
    load_value(4'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.state !== IDLE ||
          bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus4.zero !== 1'b1) begin
        errors++;
        $display("FAIL zero_start j=%0d: busy=%0b/%0b done=%0b/%0b state=%0d expected busy=0 done=0 IDLE",
                 j, bus4.busy, bus1.busy, bus4.done, bus1.done, bus4.state);
      end
      cycle();
    end
  endtask

  task automatic test_load_collision();
    load_value(4'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle();
    load = 1'b1; d = 4'd9;
    cycle();
    load = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (bus4.q !== 4'd9 || bus4.done !== 1'b0 || bus4.busy !== 1'b0 || bus4.state !== IDLE) begin
        errors++;
        $display("FAIL load_collision j=%0d: q=%0d done=%0b busy=%0b state=%0d expected q=9 done=0 busy=0 IDLE",
                 j, bus4.q, bus4.done, bus4.busy, bus4.state);
      end
      cycle();
    end
  endtask

  task automatic test_div1();
    logic [3:0] eq;
    load_value(4'd15);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int j = 0; j <= 17; j++) begin
      if (j > 0) cycle();
      eq = (j <= 15) ? 4'(15 - j) : 4'd0;
      checks++;
      if (bus1.q !== eq || bus1.done !== (j == 15) || bus1.busy !== (j < 15)) begin
        errors++;
        $display("FAIL div1 j=%0d: q=%0d done=%0b busy=%0b expected q=%0d done=%0b busy=%0b",
                 j, bus1.q, bus1.done, bus1.busy, eq, (j == 15), (j < 15));
      end
    end
  endtask

  task automatic test_async_reset();
    load_value(4'd5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle(); cycle(); cycle();
    #2 rs = 1'b0;
    #1;
    checks++;
    if (bus4.q !== 4'd0 || bus4.busy !== 1'b0 || bus4.zero !== 1'b1 || bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%0d busy=%0b zero=%0b done=%0b expected q=0 busy=0 zero=1 done=0",
               bus4.q, bus4.busy, bus4.zero, bus4.done);
    end
    model_reset();
    cycle();
    rs = 1'b1;
    load_value(4'd5);
    checks++;
    if (bus4.q !== 4'd5 || bus4.state !== IDLE || bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_after_reset: q=%0d state=%0d busy=%0b expected q=5 IDLE busy=0",
               bus4.q, bus4.state, bus4.busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] aq[2];
    logic       ab[2], ad[2], az[2];
    for (int n = 0; n < 600; n++) begin
      load  = ($urandom_range(0, 99) < 3);
      d     = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 99) < 20);
      pause = ($urandom_range(0, 99) < 15);
      cycle();
      aq[0] = bus4.q; ab[0] = bus4.busy; ad[0] = bus4.done; az[0] = bus4.zero;
      aq[1] = bus1.q; ab[1] = bus1.busy; ad[1] = bus1.done; az[1] = bus1.zero;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (aq[i] !== 4'(m_q[i]) || ab[i] !== (m_mode[i] == M_RUN || m_mode[i] == M_PAUSE) ||
            ad[i] !== m_done[i] || az[i] !== (m_q[i] == 0)) begin
          errors++;
          $display("FAIL random n=%0d dut=%0d: q=%0d busy=%0b done=%0b zero=%0b expected q=%0d busy=%0b done=%0b zero=%0b",
                   n, i, aq[i], ab[i], ad[i], az[i], m_q[i],
                   (m_mode[i] == M_RUN || m_mode[i] == M_PAUSE), m_done[i], (m_q[i] == 0));
        end
      end
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_zero_start();
    test_load_collision();
    test_div1();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_top.md
# countdown_top

Loadable 4-bit down counter with an internal clock-enable prescaler, run/pause control and a terminal-count pulse. It is the counting-down counterpart of the board's divided-clock up counter: it runs from the single board clock and uses a one-cycle tick enable instead of a derived clock. Intended for board-level timer demos, with `q` driving LEDs or a 7-segment decoder.

## Interface
- `DIV`, default 50_000_000 — number of `clk` cycles per count step; legal range ≥ 1
- `WIDTH`, default 4 — counter width
- `clk`  in  1  — board clock; all state updates on its rising edge
- `rs`  in  1  — asynchronous, active-low reset
- `load`  in  1  — when high, load `d` into the counter and abort any run
- `d`  in  WIDTH  — load value
- `start`  in  1  — begin the countdown, or resume it from pause
- `pause`  in  1  — suspend the countdown
- `q`  out  WIDTH  — current count (registered)
- `busy`  out  1  — high in RUN and PAUSE
- `done`  out  1  — one-cycle pulse when the count reaches 0 by counting
- `zero`  out  1  — high whenever `q == 0` (combinational from `q`)

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (`rs` low, asynchronous):
  - state = IDLE, `q` = 0, prescaler = 0
  - `busy` = 0, `done` = 0, `zero` = 1
- Priority within a cycle: `load` > `start` > `pause` > tick.
- `load` in any state: `q` ← `d`, state ← IDLE, prescaler ← 0.
- IDLE:
  - `start` with `q` ≠ 0 → RUN, prescaler ← 0
  - `start` with `q` == 0 is ignored (stay in IDLE, no `done`)
- RUN:
  - The prescaler counts 0..DIV-1 and wraps; `tick` = (prescaler == DIV-1).
  - On `tick`: `q` ← `q` − 1.
  - If `q` == 1 on `tick`: `q` ← 0 and state → DONE.
  - `pause` (without `start`) → PAUSE; the prescaler value is held.
  - `start` in RUN has no effect.
- PAUSE:
  - `q` and prescaler are frozen.
  - `start` → RUN and the prescaler resumes from its held value.
  - `pause` held in PAUSE has no effect.
- DONE: lasts exactly one cycle with `done` = 1, then → IDLE; `q` stays 0.
- Counter arithmetic is WIDTH-bit unsigned. The count never wraps below 0, because RUN is never entered with `q` == 0.
- `DIV` == 1: `tick` is asserted on every RUN cycle.

## Timing
- All outputs are registered, except `zero`, which is decoded from registered `q`.
- `start` sampled at edge k → state = RUN after edge k. The first decrement is at edge k+DIV.
- Subsequent decrements occur every DIV cycles while in RUN. PAUSE cycles stretch the interval by their count.
- Load value N ≥ 1 with no pauses: `done` is high during the cycle following edge k+N·DIV, i.e. exactly one cycle.
- `load` asserted in the same cycle as the final tick: the load wins, and there is no `done` pulse.
- `rs` asserted mid-run: all outputs take their reset values immediately, with no clock needed.

## Structure
- Package `countdown_pkg`:
  - state enum `cd_state_t` (IDLE, RUN, PAUSE, DONE)
  - `CD_WIDTH` = 4 default constant
- Sub-module `tick_gen` (parameter DIV; ports `clk`, `rs`, `en`, `clr`, `tick`):
  - prescaler counter of width clog2(DIV), minimum 1
  - `clr` zeroes the counter; `en` low holds it
  - `tick` is a combinational decode of (count == DIV-1) && `en`
- Top level: state machine, `q` register, output decode.

## Test plan
- Reset/load: assert `rs` low mid-count → `q`=0, `busy`=0, `zero`=1 asynchronously; then `load`=1, `d`=5 → `q`=5, state IDLE.
- Full countdown, DIV=4: load 3, pulse `start` at edge k → `q`=2,1,0 at edges k+4, k+8, k+12; `done`=1 for one cycle only; `busy` falls with DONE.
- Pause/resume, DIV=4: load 2, start, assert `pause` 2 cycles after start for 5 cycles, then `start` → first decrement at k+4+5; `q` frozen while paused.
- Start with zero: load 0, pulse `start` → stays IDLE; `busy`=0, `done` never asserts.
- Load collision, DIV=4: load 1, start, assert `load` with `d`=9 on the cycle of the final tick → `q`=9, IDLE, no `done`.
- DIV=1: load 15, start → `q` decrements every cycle; `done` 15 cycles after entering RUN.
